// File: rtl/data_ram_fill_arbiter_pkg.sv
// Shared definitions for the data RAM fill arbiter and its fill engine.
package data_ram_fill_arbiter_pkg;

  localparam int ADDR_W_DEFAULT = 12;
  localparam int DATA_W_DEFAULT = 32;
  localparam int DATA_RAM_WORDS = 4096;

  typedef enum logic [1:0] {
    FILL_IDLE   = 2'd0,
    FILL_ACTIVE = 2'd1,
    FILL_DONE   = 2'd2
  } fill_state_t;

endpackage

// File: rtl/data_ram_fill_engine.sv
// Fill engine: walks a pointer over [base, base+len) writing a constant word,
// advancing only on steps where the arbiter grants it the RAM port.
module data_ram_fill_engine
  import data_ram_fill_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] value,
  input  logic              advance,
  output logic [ADDR_W-1:0] ptr,
  output logic [DATA_W-1:0] word,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(1) << ADDR_W;

  fill_state_t     state;
  fill_state_t     state_next;
  logic [ADDR_W:0] remaining;
  logic [ADDR_W:0] len_eff;

  // Requests longer than the whole RAM are clamped to one full pass.
  always_comb begin
    len_eff = (len > MAX_LEN) ? MAX_LEN : len;
  end

  // Next-state logic; a zero-length request goes straight to DONE.
  always_comb begin
    state_next = state;
    case (state)
      FILL_IDLE: begin
        if (start) state_next = (len_eff == '0) ? FILL_DONE : FILL_ACTIVE;
      end
      FILL_ACTIVE: begin
        if (advance && remaining == (ADDR_W+1)'(1)) state_next = FILL_DONE;
      end
      FILL_DONE: state_next = FILL_IDLE;
      default:   state_next = FILL_IDLE;
    endcase
  end

  // State register; DONE lasts exactly one clock even when tick is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL_IDLE;
    end else if (tick || state == FILL_DONE) begin
      state <= state_next;
    end
  end

  // Latch the request on start, then step pointer and count on each granted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      remaining <= '0;
      word      <= '0;
    end else if (tick) begin
      if (state == FILL_IDLE && start && len_eff != '0) begin
        ptr       <= base;
        remaining <= len_eff;
        word      <= value;
      end else if (state == FILL_ACTIVE && advance) begin
        ptr       <= ptr + ADDR_W'(1);
        remaining <= remaining - (ADDR_W+1)'(1);
      end
    end
  end

  assign busy = (state == FILL_ACTIVE);
  assign done = (state == FILL_DONE);

endmodule

// File: rtl/data_ram_fill_arbiter.sv
// Shares the CPU-side data RAM port between CPU loads/stores and the fill engine.
// The CPU wins by default; after STARVE_MAX consecutive CPU grants the fill gets one slot.
module data_ram_fill_arbiter
  import data_ram_fill_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEFAULT,
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_d,
  input  logic              cpu_we,
  input  logic              cpu_re,
  output logic [DATA_W-1:0] cpu_q,
  output logic              cpu_stall,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [ADDR_W:0]   fill_len,
  input  logic [DATA_W-1:0] fill_value,
  output logic              fill_busy,
  output logic              fill_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_d,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);

  logic                cpu_req;
  logic                fill_gnt;
  logic [STARVE_W-1:0] starve_cnt;
  logic [ADDR_W-1:0]   fill_ptr;
  logic [DATA_W-1:0]   fill_word;

  data_ram_fill_engine #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_engine (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .start   (fill_start),
    .base    (fill_base),
    .len     (fill_len),
    .value   (fill_value),
    .advance (fill_gnt),
    .ptr     (fill_ptr),
    .word    (fill_word),
    .busy    (fill_busy),
    .done    (fill_done)
  );

  // Grant: fill takes the port when the CPU is quiet or has starved it long enough.
  always_comb begin
    cpu_req  = cpu_we | cpu_re;
    fill_gnt = fill_busy && (!cpu_req || starve_cnt == STARVE_LIMIT);
  end

  // Port mux; the CPU path is a straight pass-through so granted loads see no latency.
  always_comb begin
    ram_addr = cpu_addr;
    ram_d    = cpu_d;
    ram_we   = cpu_we;
    if (fill_gnt) begin
      ram_addr = fill_ptr;
      ram_d    = fill_word;
      ram_we   = 1'b1;
    end
  end

  assign cpu_q     = ram_q;
  assign cpu_stall = cpu_req & fill_gnt;

  // Count consecutive CPU wins while a fill waits; cleared whenever the fill gets through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (tick) begin
      if (!fill_busy || fill_gnt) begin
        starve_cnt <= '0;
      end else if (cpu_req && starve_cnt != STARVE_LIMIT) begin
        starve_cnt <= starve_cnt + STARVE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_data_ram_fill_arbiter.sv
// Testbench for data_ram_fill_arbiter: a behavioural RAM plus a reference memory
// image and fill schedule derived from the arbitration rules.
module tb_data_ram_fill_arbiter;
  import data_ram_fill_arbiter_pkg::*;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_d;
  logic        cpu_we;
  logic        cpu_re;
  logic [31:0] cpu_q;
  logic        cpu_stall;
  logic        fill_start;
  logic [11:0] fill_base;
  logic [12:0] fill_len;
  logic [31:0] fill_value;
  logic        fill_busy;
  logic        fill_done;
  logic [11:0] ram_addr;
  logic [31:0] ram_d;
  logic        ram_we;
  logic [31:0] ram_q;

  logic [31:0] mem     [DATA_RAM_WORDS];
  logic [31:0] exp_mem [DATA_RAM_WORDS];

  int n_checks = 0;
  int n_pass   = 0;

  data_ram_fill_arbiter #(
    .ADDR_W     (12),
    .DATA_W     (32),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .cpu_addr   (cpu_addr),
    .cpu_d      (cpu_d),
    .cpu_we     (cpu_we),
    .cpu_re     (cpu_re),
    .cpu_q      (cpu_q),
    .cpu_stall  (cpu_stall),
    .fill_start (fill_start),
    .fill_base  (fill_base),
    .fill_len   (fill_len),
    .fill_value (fill_value),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .ram_addr   (ram_addr),
    .ram_d      (ram_d),
    .ram_we     (ram_we),
    .ram_q      (ram_q)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] seed_word(input int i);
    return 32'hC3A5_0000 ^ 32'(i * 7919);
  endfunction

  function automatic int mem_diffs();
    int n = 0;
    for (int i = 0; i < DATA_RAM_WORDS; i++) if (mem[i] !== exp_mem[i]) n++;
    return n;
  endfunction

  // Behavioural RAM: asynchronous read, write only on steps.
  assign ram_q = mem[ram_addr];
  always @(posedge clk) begin
    if (tick && ram_we) mem[ram_addr] = ram_d;
  end

  initial begin
    for (int i = 0; i < DATA_RAM_WORDS; i++) mem[i] = seed_word(i);
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout reached");
    $fatal(1);
  end

  task automatic test_reset();
    rst_n = 1'b0; tick = 1'b0; fill_start = 1'b0; fill_base = '0; fill_len = '0; fill_value = '0;
    cpu_addr = 12'h055; cpu_we = 1'b1; cpu_re = 1'b0; cpu_d = 32'h1234_5678;
    #1;
    n_checks++; if (fill_busy !== 1'b0) $display("[TB] FAIL reset_busy got %b exp 0", fill_busy); else n_pass++;
    n_checks++; if (fill_done !== 1'b0) $display("[TB] FAIL reset_done got %b exp 0", fill_done); else n_pass++;
    n_checks++; if (cpu_stall !== 1'b0) $display("[TB] FAIL reset_stall got %b exp 0", cpu_stall); else n_pass++;
    n_checks++; if (ram_addr !== 12'h055) $display("[TB] FAIL reset_addr got %h exp 055", ram_addr); else n_pass++;
    n_checks++; if (ram_we !== 1'b1) $display("[TB] FAIL reset_we got %b exp 1", ram_we); else n_pass++;
    n_checks++; if (ram_d !== 32'h1234_5678) $display("[TB] FAIL reset_d got %h exp 12345678", ram_d); else n_pass++;
    @(negedge clk);
    cpu_we = 1'b0; rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill(input string tag, input logic [11:0] base, input int len, input logic [31:0] value);
    logic [11:0] a;
    tick = 1'b1; cpu_we = 1'b0; cpu_re = 1'b0;
    fill_start = 1'b1; fill_base = base; fill_len = 13'(len); fill_value = value;
    #1;
    n_checks++; if (ram_we !== 1'b0) $display("[TB] FAIL %s_idle_we got %b exp 0", tag, ram_we); else n_pass++;
    @(negedge clk);
    fill_start = 1'b0; fill_base = base + 12'h123; fill_value = ~value;
    for (int i = 0; i < len; i++) begin
      a = 12'(base + 12'(i));
      #1;
      n_checks++; if (fill_busy !== 1'b1) $display("[TB] FAIL %s_busy step %0d got %b exp 1", tag, i, fill_busy); else n_pass++;
      n_checks++; if (ram_we !== 1'b1) $display("[TB] FAIL %s_we step %0d got %b exp 1", tag, i, ram_we); else n_pass++;
      n_checks++; if (ram_addr !== a) $display("[TB] FAIL %s_addr step %0d got %h exp %h", tag, i, ram_addr, a); else n_pass++;
      n_checks++; if (ram_d !== value) $display("[TB] FAIL %s_data step %0d got %h exp %h", tag, i, ram_d, value); else n_pass++;
      exp_mem[a] = value;
      @(negedge clk);
    end
    #1;
    n_checks++; if (fill_done !== 1'b1) $display("[TB] FAIL %s_done got %b exp 1", tag, fill_done); else n_pass++;
    n_checks++; if (fill_busy !== 1'b0) $display("[TB] FAIL %s_busy_end got %b exp 0", tag, fill_busy); else n_pass++;
    @(negedge clk);
    #1;
    n_checks++; if (fill_done !== 1'b0) $display("[TB] FAIL %s_done_pulse got %b exp 0", tag, fill_done); else n_pass++;
    n_checks++; if (mem_diffs() !== 0) $display("[TB] FAIL %s_mem got %0d diffs exp 0", tag, mem_diffs()); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic [11:0] base = 12'($urandom);
    logic [31:0] value = $urandom;
    logic [11:0] a;
    bit exp_stall;
    int len = 3;
    tick = 1'b1; cpu_we = 1'b0; cpu_re = 1'b1; cpu_addr = 12'($urandom);
    fill_start = 1'b1; fill_base = base; fill_len = 13'(len); fill_value = value;
    #1;
    n_checks++; if (cpu_stall !== 1'b0) $display("[TB] FAIL cont_start_stall got %b exp 0", cpu_stall); else n_pass++;
    @(negedge clk);
    fill_start = 1'b0;
    for (int k = 0; k < len * (STARVE_MAX + 1); k++) begin
      cpu_addr = (k % 2 == 1) ? 12'(base + 12'($urandom_range(0, 2))) : 12'($urandom);
      exp_stall = (k % (STARVE_MAX + 1)) == STARVE_MAX;
      a = 12'(base + 12'(k / (STARVE_MAX + 1)));
      #1;
      n_checks++; if (cpu_stall !== exp_stall) $display("[TB] FAIL cont_stall step %0d got %b exp %b", k, cpu_stall, exp_stall); else n_pass++;
      n_checks++; if (fill_busy !== 1'b1) $display("[TB] FAIL cont_busy step %0d got %b exp 1", k, fill_busy); else n_pass++;
      if (exp_stall) begin
        n_checks++; if (ram_addr !== a) $display("[TB] FAIL cont_fill_addr step %0d got %h exp %h", k, ram_addr, a); else n_pass++;
        exp_mem[a] = value;
      end else begin
        n_checks++; if (cpu_q !== exp_mem[cpu_addr]) $display("[TB] FAIL cont_load step %0d got %h exp %h", k, cpu_q, exp_mem[cpu_addr]); else n_pass++;
        n_checks++; if (ram_we !== 1'b0) $display("[TB] FAIL cont_we step %0d got %b exp 0", k, ram_we); else n_pass++;
      end
      @(negedge clk);
    end
    #1;
    n_checks++; if (fill_done !== 1'b1) $display("[TB] FAIL cont_done got %b exp 1", fill_done); else n_pass++;
    cpu_re = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_diffs() !== 0) $display("[TB] FAIL cont_mem got %0d diffs exp 0", mem_diffs()); else n_pass++;
  endtask

  task automatic test_len_zero();
    tick = 1'b1; cpu_we = 1'b0; cpu_re = 1'b0;
    fill_start = 1'b1; fill_base = 12'($urandom); fill_len = 13'd0; fill_value = $urandom;
    #1;
    n_checks++; if (ram_we !== 1'b0) $display("[TB] FAIL len0_we_start got %b exp 0", ram_we); else n_pass++;
    @(negedge clk);
    fill_start = 1'b0;
    #1;
    n_checks++; if (fill_done !== 1'b1) $display("[TB] FAIL len0_done got %b exp 1", fill_done); else n_pass++;
    n_checks++; if (fill_busy !== 1'b0) $display("[TB] FAIL len0_busy got %b exp 0", fill_busy); else n_pass++;
    n_checks++; if (ram_we !== 1'b0) $display("[TB] FAIL len0_we got %b exp 0", ram_we); else n_pass++;
    @(negedge clk);
    #1;
    n_checks++; if (fill_done !== 1'b0) $display("[TB] FAIL len0_done_pulse got %b exp 0", fill_done); else n_pass++;
    n_checks++; if (mem_diffs() !== 0) $display("[TB] FAIL len0_mem got %0d diffs exp 0", mem_diffs()); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    logic [11:0] base = 12'($urandom);
    logic [31:0] value = $urandom;
    logic [11:0] a;
    tick = 1'b1; cpu_we = 1'b0; cpu_re = 1'b0;
    fill_start = 1'b1; fill_base = base; fill_len = 13'd3; fill_value = value;
    @(negedge clk);
    fill_base = base + 12'h400; fill_len = 13'd5; fill_value = ~value;
    for (int i = 0; i < 3; i++) begin
      a = 12'(base + 12'(i));
      #1;
      n_checks++; if (ram_addr !== a) $display("[TB] FAIL ign_addr step %0d got %h exp %h", i, ram_addr, a); else n_pass++;
      n_checks++; if (ram_d !== value) $display("[TB] FAIL ign_data step %0d got %h exp %h", i, ram_d, value); else n_pass++;
      exp_mem[a] = value;
      @(negedge clk);
    end
    #1;
    n_checks++; if (fill_done !== 1'b1) $display("[TB] FAIL ign_done got %b exp 1", fill_done); else n_pass++;
    @(negedge clk);
    fill_start = 1'b0;
    #1;
    n_checks++; if (fill_busy !== 1'b0) $display("[TB] FAIL ign_restart got %b exp 0", fill_busy); else n_pass++;
    n_checks++; if (mem_diffs() !== 0) $display("[TB] FAIL ign_mem got %0d diffs exp 0", mem_diffs()); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_random_traffic(input int len);
    logic [11:0] base = 12'($urandom);
    logic [31:0] value = $urandom;
    logic [11:0] ptr = base;
    int remaining = len;
    int cpu_run = 0;
    int steps = 0;
    int r;
    bit hold = 1'b0;
    bit req;
    bit exp_fill;
    tick = 1'b1; cpu_we = 1'b0; cpu_re = 1'b0;
    fill_start = 1'b1; fill_base = base; fill_len = 13'(len); fill_value = value;
    @(negedge clk);
    fill_start = 1'b0;
    while (remaining > 0 && steps < 40 * len) begin
      if (!hold) begin
        r = $urandom_range(0, 3);
        cpu_we = (r == 1);
        cpu_re = (r >= 2);
        cpu_addr = ($urandom_range(0, 1) == 1) ? 12'(base + 12'($urandom_range(0, len))) : 12'($urandom);
        cpu_d = $urandom;
      end
      req = cpu_we | cpu_re;
      // The fill writes when the CPU is quiet or has already won STARVE_MAX steps in a row.
      exp_fill = !req || cpu_run == STARVE_MAX;
      #1;
      n_checks++; if (cpu_stall !== (req && exp_fill)) $display("[TB] FAIL rnd_stall step %0d got %b exp %b", steps, cpu_stall, req && exp_fill); else n_pass++;
      if (exp_fill) begin
        n_checks++; if (ram_we !== 1'b1 || ram_addr !== ptr) $display("[TB] FAIL rnd_fill step %0d got we=%b addr=%h exp we=1 addr=%h", steps, ram_we, ram_addr, ptr); else n_pass++;
        exp_mem[ptr] = value;
        ptr = ptr + 12'd1;
        remaining--;
        cpu_run = 0;
      end else begin
        n_checks++; if (ram_we !== cpu_we || ram_addr !== cpu_addr) $display("[TB] FAIL rnd_cpu step %0d got we=%b addr=%h exp we=%b addr=%h", steps, ram_we, ram_addr, cpu_we, cpu_addr); else n_pass++;
        if (cpu_re) begin
          n_checks++; if (cpu_q !== exp_mem[cpu_addr]) $display("[TB] FAIL rnd_load step %0d got %h exp %h", steps, cpu_q, exp_mem[cpu_addr]); else n_pass++;
        end
        if (cpu_we) exp_mem[cpu_addr] = cpu_d;
        cpu_run++;
      end
      hold = req && exp_fill;
      steps++;
      @(negedge clk);
    end
    cpu_we = 1'b0; cpu_re = 1'b0;
    #1;
    n_checks++; if (fill_done !== 1'b1 || fill_busy !== 1'b0) $display("[TB] FAIL rnd_done len %0d got done=%b busy=%b exp done=1 busy=0", len, fill_done, fill_busy); else n_pass++;
    @(negedge clk);
    n_checks++; if (mem_diffs() !== 0) $display("[TB] FAIL rnd_mem got %0d diffs exp 0", mem_diffs()); else n_pass++;
  endtask

  task automatic test_reset_abort();
    logic [11:0] base = 12'($urandom);
    logic [31:0] value = $urandom;
    tick = 1'b1; cpu_we = 1'b0; cpu_re = 1'b0;
    fill_start = 1'b1; fill_base = base; fill_len = 13'd8; fill_value = value;
    @(negedge clk);
    fill_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_mem[12'(base + 12'(i))] = value;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    n_checks++; if (fill_busy !== 1'b0) $display("[TB] FAIL abort_busy got %b exp 0", fill_busy); else n_pass++;
    n_checks++; if (ram_we !== 1'b0) $display("[TB] FAIL abort_we got %b exp 0", ram_we); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    n_checks++; if (fill_busy !== 1'b0) $display("[TB] FAIL abort_resume got %b exp 0", fill_busy); else n_pass++;
    n_checks++; if (mem_diffs() !== 0) $display("[TB] FAIL abort_mem got %0d diffs exp 0", mem_diffs()); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_tick_gate();
    logic [11:0] base = 12'($urandom);
    logic [31:0] value = $urandom;
    logic [11:0] a;
    tick = 1'b1; cpu_we = 1'b0; cpu_re = 1'b0;
    fill_start = 1'b1; fill_base = base; fill_len = 13'd4; fill_value = value;
    @(negedge clk);
    fill_start = 1'b0;
    exp_mem[base] = value;
    @(negedge clk);
    tick = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++; if (fill_busy !== 1'b1) $display("[TB] FAIL gate_busy clk %0d got %b exp 1", c, fill_busy); else n_pass++;
      n_checks++; if (ram_addr !== 12'(base + 12'd1)) $display("[TB] FAIL gate_addr clk %0d got %h exp %h", c, ram_addr, 12'(base + 12'd1)); else n_pass++;
      @(negedge clk);
    end
    n_checks++; if (mem_diffs() !== 0) $display("[TB] FAIL gate_mem_hold got %0d diffs exp 0", mem_diffs()); else n_pass++;
    tick = 1'b1;
    for (int i = 1; i < 4; i++) begin
      a = 12'(base + 12'(i));
      #1;
      n_checks++; if (ram_addr !== a) $display("[TB] FAIL gate_addr_resume step %0d got %h exp %h", i, ram_addr, a); else n_pass++;
      exp_mem[a] = value;
      @(negedge clk);
    end
    #1;
    n_checks++; if (fill_done !== 1'b1) $display("[TB] FAIL gate_done got %b exp 1", fill_done); else n_pass++;
    @(negedge clk);
    n_checks++; if (mem_diffs() !== 0) $display("[TB] FAIL gate_mem got %0d diffs exp 0", mem_diffs()); else n_pass++;
  endtask

  task automatic test_clamp();
    logic [11:0] base = 12'($urandom);
    logic [31:0] value = $urandom;
    int cnt = 0;
    tick = 1'b1; cpu_we = 1'b0; cpu_re = 1'b0;
    fill_start = 1'b1; fill_base = base; fill_len = 13'h1FFF; fill_value = value;
    @(negedge clk);
    fill_start = 1'b0;
    while (cnt < 5000) begin
      #1;
      if (!fill_busy) break;
      exp_mem[12'(base + 12'(cnt))] = value;
      cnt++;
      @(negedge clk);
    end
    n_checks++; if (cnt !== DATA_RAM_WORDS) $display("[TB] FAIL clamp_len got %0d exp %0d", cnt, DATA_RAM_WORDS); else n_pass++;
    n_checks++; if (fill_done !== 1'b1) $display("[TB] FAIL clamp_done got %b exp 1", fill_done); else n_pass++;
    @(negedge clk);
    n_checks++; if (mem_diffs() !== 0) $display("[TB] FAIL clamp_mem got %0d diffs exp 0", mem_diffs()); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < DATA_RAM_WORDS; i++) exp_mem[i] = seed_word(i);
    test_reset();
    test_fill("basic", 12'h100, 4, 32'hDEAD_BEEF);
    test_fill("wrap", 12'hFFE, 4, $urandom);
    test_contention();
    test_len_zero();
    test_start_ignored();
    test_random_traffic(5);
    test_random_traffic(9);
    test_reset_abort();
    test_tick_gate();
    test_clamp();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
